sobel_thresh_ctrl: RTL and testbench
====================================

Name: sobel_thresh_ctrl

Overview:
- Frame-level threshold controller for the Sobel edge detector.
- Monitors the detector's binary output stream and counts edge pixels and active pixels per frame.
- At each frame boundary, drives the detector's 8-bit `thresh` input. In auto mode it steers the edge density toward a target; in manual mode it takes a host value.
- `thresh` only changes between frames, so it is constant for every pixel of a frame.

Parameters:
- IMG_HDISP, 11'd640, active pixels per line.
- IMG_VDISP, 11'd480, active lines per frame.
- INIT_THRESH, 8'd80, `thresh` value after reset.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_auto  in  1  1 = adaptive mode, 0 = manual mode
- cfg_thresh_manual  in  8  threshold used in manual mode
- cfg_target  in  20  target edge-pixel count per frame
- cfg_hyst  in  20  dead band around the target
- cfg_step  in  4  adjustment step per frame (0 = freeze)
- cfg_thresh_min  in  8  lower clamp
- cfg_thresh_max  in  8  upper clamp (min <= max is guaranteed by software)
- det_vsync  in  1  detector post_img_vsync; high for the whole frame
- det_href  in  1  detector post_img_href; pixel valid
- det_bit  in  1  detector post_img_bit; edge flag
- thresh  out  8  threshold to the detector
- edge_cnt  out  20  edge count of the last completed frame
- frame_done  out  1  one-cycle pulse when a frame has been evaluated
- frame_err  out  1  one-cycle pulse, coincident with frame_done, when the pixel count is wrong

Behaviour:
- Reset values: thresh=INIT_THRESH, edge_cnt=0, frame_done=0, frame_err=0, all internal counters 0, state IDLE.
- Reset is honoured in any state, including mid-frame.
- det_vsync is registered into vs_d.
  - Rise: vs_d=0 and det_vsync=1.
  - Fall: vs_d=1 and det_vsync=0.
- A rise seen outside IDLE sets `pend`; IDLE consumes `pend` immediately.
- FSM transitions:
  - IDLE -> COUNT on a rise (or `pend`). Clear the pixel and edge counters.
  - COUNT: every cycle with det_href=1, increment pix_cnt (21 bit, saturating). If det_bit=1 as well, increment e_cnt (20 bit, saturating at 0xFFFFF).
  - COUNT -> CALC on a fall, or on a rise while still counting (a missing fall is treated as frame end plus `pend`).
  - CALC (1 cycle): compute `hi` and `lo`, and set `bad` if pix_cnt != IMG_HDISP*IMG_VDISP.
    - hi = e_cnt > cfg_target+cfg_hyst, using a 21-bit sum.
    - lo = cfg_target >= cfg_hyst and e_cnt < cfg_target-cfg_hyst.
  - CALC -> APPLY (1 cycle) -> IDLE. Registers update at the end of APPLY.
- Output timing: if the fall is sampled at edge T, then thresh, edge_cnt, frame_done and frame_err are valid after edge T+2.
- APPLY update rules:
  - edge_cnt <= e_cnt.
  - frame_done <= 1; frame_err <= bad.
  - Manual mode: thresh <= cfg_thresh_manual. No clamping is applied.
  - Auto mode with bad=1: hold thresh.
  - Auto mode, hi: thresh <= min(thresh+cfg_step, cfg_thresh_max). Compute in 9 bits so there is no wrap.
  - Auto mode, lo: thresh <= max(thresh-cfg_step, cfg_thresh_min). Compute in 9 bits signed so there is no underflow.
  - Auto mode, otherwise: hold.
- cfg_* signals are sampled only in CALC/APPLY. A mode or config change mid-frame takes effect at the next frame boundary.
- Pixels arriving while in IDLE/CALC/APPLY are not counted. They will cause `bad` on that frame.
- After reset, a frame already in progress (vsync high at reset release) is ignored until the next rise.

Test Plan:
- Reset: IMG_HDISP=8, IMG_VDISP=4, hold rst_n=0 -> thresh=80, edge_cnt=0, frame_done=0, frame_err=0. Release rst_n with det_vsync already high -> no frame_done at that frame's fall.
- Auto up-step: cfg_target=10, hyst=2, step=4, min=0, max=255; 32-pixel frame with 20 det_bit=1 -> 2 cycles after the fall, thresh=84, edge_cnt=20, frame_done pulses exactly 1 cycle, frame_err=0.
- Down-step and clamp: from thresh=84, frames with 5 edges, min=78 -> thresh becomes 80, then 78, then stays 78. A frame with 11 edges (inside the dead band) -> thresh unchanged.
- Manual override: set cfg_auto=0, cfg_thresh_manual=0x30 mid-frame -> thresh unchanged during the frame, becomes 0x30 at frame end. cfg_thresh_manual=0xFF with max=0x80 -> thresh=0xFF (no clamp in manual).
- Bad frame: auto mode, frame with 31 valid pixels and 30 edges -> frame_err=1 with frame_done, edge_cnt=30, thresh held.
- Mid-frame reset and missing fall: assert rst_n after 10 pixels -> outputs return to reset values and no frame_done. Separately, issue a second rise without an intervening fall -> the first frame is evaluated, and the second frame is counted from its start and evaluated normally.

Source files
------------

// File: rtl/sobel_thresh_ctrl.sv
// Frame-level threshold controller for the Sobel edge detector.
// Counts edge/active pixels per frame and updates the detector threshold between frames.
module sobel_thresh_ctrl #(
    parameter logic [10:0] IMG_HDISP   = 11'd640,
    parameter logic [10:0] IMG_VDISP   = 11'd480,
    parameter logic [7:0]  INIT_THRESH = 8'd80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_auto,
    input  logic [7:0]  cfg_thresh_manual,
    input  logic [19:0] cfg_target,
    input  logic [19:0] cfg_hyst,
    input  logic [3:0]  cfg_step,
    input  logic [7:0]  cfg_thresh_min,
    input  logic [7:0]  cfg_thresh_max,
    input  logic        det_vsync,
    input  logic        det_href,
    input  logic        det_bit,
    output logic [7:0]  thresh,
    output logic [19:0] edge_cnt,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [20:0] FRAME_PIX = 21'(IMG_HDISP) * 21'(IMG_VDISP);

    typedef enum logic [1:0] {IDLE, COUNT, CALC, APPLY} state_t;

    state_t      state, state_nxt;
    logic        vs_d, primed, pend;
    logic        rise, fall;
    logic [20:0] pix_cnt;
    logic [19:0] e_cnt;
    logic        hi, lo, bad;
    logic [20:0] hi_lim;
    logic        hi_c, lo_c;
    logic [8:0]  up_sum;
    logic signed [8:0] dn_diff;
    logic [7:0]  thresh_nxt;

    // primed masks the first sample after reset so a frame already in flight is not seen as a rise
    assign rise = primed & det_vsync & ~vs_d;
    assign fall = vs_d & ~det_vsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise || pend) state_nxt = COUNT;
            COUNT:   if (fall || rise) state_nxt = CALC;
            CALC:    state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hi_lim = {1'b0, cfg_target} + {1'b0, cfg_hyst};
        hi_c   = {1'b0, e_cnt} > hi_lim;
        lo_c   = (cfg_target >= cfg_hyst) && (e_cnt < (cfg_target - cfg_hyst));
    end

    // 9-bit arithmetic keeps thresh+step from wrapping and thresh-step from underflowing
    always_comb begin
        up_sum     = {1'b0, thresh} + {5'b0, cfg_step};
        dn_diff    = $signed({1'b0, thresh}) - $signed({5'b0, cfg_step});
        thresh_nxt = thresh;
        if (!cfg_auto) begin
            thresh_nxt = cfg_thresh_manual;
        end else if (!bad) begin
            if (hi)
                thresh_nxt = (up_sum > {1'b0, cfg_thresh_max}) ? cfg_thresh_max : up_sum[7:0];
            else if (lo)
                thresh_nxt = (dn_diff < $signed({1'b0, cfg_thresh_min})) ? cfg_thresh_min
                                                                          : dn_diff[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= 1'b0;
            primed     <= 1'b0;
            pend       <= 1'b0;
            pix_cnt    <= '0;
            e_cnt      <= '0;
            hi         <= 1'b0;
            lo         <= 1'b0;
            bad        <= 1'b0;
            thresh     <= INIT_THRESH;
            edge_cnt   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vs_d       <= det_vsync;
            primed     <= 1'b1;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (state != IDLE && rise) pend <= 1'b1;
            else if (state == IDLE)    pend <= 1'b0;

            if (state == IDLE && state_nxt == COUNT) begin
                pix_cnt <= '0;
                e_cnt   <= '0;
            end

            if (state == COUNT && det_href) begin
                if (pix_cnt != '1) pix_cnt <= pix_cnt + 21'd1;
                if (det_bit && e_cnt != '1) e_cnt <= e_cnt + 20'd1;
            end

            if (state == CALC) begin
                hi  <= hi_c;
                lo  <= lo_c;
                bad <= (pix_cnt != FRAME_PIX);
            end

            if (state == APPLY) begin
                edge_cnt   <= e_cnt;
                frame_done <= 1'b1;
                frame_err  <= bad;
                thresh     <= thresh_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sobel_thresh_ctrl.sv
// Self-checking bench for sobel_thresh_ctrl on a small 8x4 frame, directed plus random frames
// checked against an integer reference model of the threshold update rules.
module tb_sobel_thresh_ctrl;

    localparam int NPIX = 32;

    logic        clk;
    logic        rst_n;
    logic        cfg_auto;
    logic [7:0]  cfg_thresh_manual;
    logic [19:0] cfg_target;
    logic [19:0] cfg_hyst;
    logic [3:0]  cfg_step;
    logic [7:0]  cfg_thresh_min;
    logic [7:0]  cfg_thresh_max;
    logic        det_vsync;
    logic        det_href;
    logic        det_bit;
    logic [7:0]  thresh;
    logic [19:0] edge_cnt;
    logic        frame_done;
    logic        frame_err;

    int n_cmp;
    int n_bad;
    int exp_thresh;
    int cur_pix;
    int cur_edges;

    sobel_thresh_ctrl #(
        .IMG_HDISP  (11'd8),
        .IMG_VDISP  (11'd4),
        .INIT_THRESH(8'd80)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_auto         (cfg_auto),
        .cfg_thresh_manual(cfg_thresh_manual),
        .cfg_target       (cfg_target),
        .cfg_hyst         (cfg_hyst),
        .cfg_step         (cfg_step),
        .cfg_thresh_min   (cfg_thresh_min),
        .cfg_thresh_max   (cfg_thresh_max),
        .det_vsync        (det_vsync),
        .det_href         (det_href),
        .det_bit          (det_bit),
        .thresh           (thresh),
        .edge_cnt         (edge_cnt),
        .frame_done       (frame_done),
        .frame_err        (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Threshold after a frame, from the controller's rules in plain integer arithmetic
    function automatic int ref_thresh(input int t, input int pix, input int e);
        int tgt, hy, st, mn, mx;
        tgt = int'(cfg_target);
        hy  = int'(cfg_hyst);
        st  = int'(cfg_step);
        mn  = int'(cfg_thresh_min);
        mx  = int'(cfg_thresh_max);
        if (!cfg_auto) return int'(cfg_thresh_manual);
        if (pix != NPIX) return t;
        if (e > tgt + hy) return (t + st > mx) ? mx : t + st;
        if (tgt >= hy && e < tgt - hy) return (t - st < mn) ? mn : t - st;
        return t;
    endfunction

    task automatic send_pixels(input int n, input int k, input int gap_max);
        int r;
        logic b;
        r = k;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(negedge clk);
                det_href = 1'b0;
                det_bit  = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            b        = ($urandom_range(n - i - 1, 0) < r);
            det_href = 1'b1;
            det_bit  = b;
            r        = r - int'(b);
            cur_pix++;
            cur_edges += int'(b);
        end
        @(negedge clk);
        det_href = 1'b0;
        det_bit  = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        det_vsync = 1'b1;
        det_href  = 1'b0;
        cur_pix   = 0;
        cur_edges = 0;
        @(negedge clk);
    endtask

    // Drops vsync and checks the evaluation lands exactly two edges after the fall is sampled
    task automatic end_frame(input string tag, input bit reraise);
        int prev;
        int exp_e;
        bit exp_err;
        prev    = exp_thresh;
        exp_e   = cur_edges;
        exp_err = (cur_pix != NPIX);
        @(negedge clk);
        det_vsync = 1'b0;
        det_href  = 1'b0;
        exp_thresh = ref_thresh(prev, cur_pix, cur_edges);
        @(negedge clk);
        if (reraise) det_vsync = 1'b1;
        check({tag, ".done_t1"}, 32'(frame_done), 32'd0);
        check({tag, ".thresh_hold"}, 32'(thresh), prev);
        @(negedge clk);
        check({tag, ".done_t2"}, 32'(frame_done), 32'd0);
        @(negedge clk);
        check({tag, ".done"}, 32'(frame_done), 32'd1);
        check({tag, ".err"}, 32'(frame_err), 32'(exp_err));
        check({tag, ".thresh"}, 32'(thresh), exp_thresh);
        check({tag, ".edge_cnt"}, 32'(edge_cnt), exp_e);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(frame_done), 32'd0);
        if (reraise) begin
            cur_pix   = 0;
            cur_edges = 0;
        end
    endtask

    task automatic watch_no_done(input string tag);
        int seen;
        seen = 0;
        @(negedge clk);
        det_vsync = 1'b0;
        det_href  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (frame_done) seen++;
        end
        check({tag, ".no_done"}, 32'(seen), 32'd0);
        check({tag, ".thresh"}, 32'(thresh), exp_thresh);
    endtask

    task automatic set_auto(input int tgt, input int hy, input int st, input int mn, input int mx);
        cfg_auto       = 1'b1;
        cfg_target     = 20'(tgt);
        cfg_hyst       = 20'(hy);
        cfg_step       = 4'(st);
        cfg_thresh_min = 8'(mn);
        cfg_thresh_max = 8'(mx);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cur_pix = 0;
        cur_edges = 0;
        exp_thresh = 80;
        rst_n = 1'b0;
        det_vsync = 1'b1;
        det_href = 1'b0;
        det_bit = 1'b0;
        cfg_thresh_manual = 8'h00;
        set_auto(10, 2, 4, 0, 255);

        // Reset values, then release inside a frame that must be ignored
        repeat (3) @(negedge clk);
        check("reset.thresh", 32'(thresh), 32'd80);
        check("reset.edge_cnt", 32'(edge_cnt), 32'd0);
        check("reset.done", 32'(frame_done), 32'd0);
        check("reset.err", 32'(frame_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_pixels(NPIX, 20, 1);
        watch_no_done("late_frame");

        // Auto up-step, then down-steps into the clamp and a dead-band frame
        start_frame(); send_pixels(NPIX, 20, 2); end_frame("up", 1'b0);
        set_auto(10, 2, 4, 78, 255);
        start_frame(); send_pixels(NPIX, 5, 1); end_frame("down1", 1'b0);
        start_frame(); send_pixels(NPIX, 5, 1); end_frame("down2", 1'b0);
        start_frame(); send_pixels(NPIX, 5, 1); end_frame("clamp", 1'b0);
        start_frame(); send_pixels(NPIX, 11, 1); end_frame("deadband", 1'b0);

        // Manual mode selected mid-frame; manual value bypasses the clamps
        start_frame();
        send_pixels(16, 8, 1);
        cfg_auto = 1'b0;
        cfg_thresh_manual = 8'h30;
        @(negedge clk);
        check("manual.midframe", 32'(thresh), exp_thresh);
        send_pixels(16, 8, 1);
        end_frame("manual30", 1'b0);
        cfg_thresh_manual = 8'hFF;
        cfg_thresh_max = 8'h80;
        start_frame(); send_pixels(NPIX, 3, 1); end_frame("manualFF", 1'b0);

        // Short frame in auto mode: error flagged, threshold held
        set_auto(10, 2, 4, 0, 255);
        start_frame(); send_pixels(31, 30, 1); end_frame("bad", 1'b0);

        // Random configurations and frames, occasionally with a wrong pixel count
        for (int f = 0; f < 12; f++) begin
            int n;
            int k;
            int mn;
            @(negedge clk);
            mn = $urandom_range(100, 0);
            set_auto($urandom_range(32, 0), $urandom_range(8, 0), $urandom_range(15, 0),
                     mn, $urandom_range(255, mn));
            cfg_auto = ($urandom_range(4, 0) != 0);
            cfg_thresh_manual = 8'($urandom_range(255, 0));
            n = ($urandom_range(5, 0) == 0) ? 31 + 2 * int'($urandom_range(1, 0)) : NPIX;
            k = $urandom_range(n, 0);
            start_frame(); send_pixels(n, k, 3); end_frame("rand", 1'b0);
        end

        // Vsync drops for one cycle and rises again: both frames evaluated
        set_auto(10, 2, 4, 0, 255);
        start_frame();
        send_pixels(NPIX, 25, 1);
        end_frame("back2back_a", 1'b1);
        send_pixels(NPIX, 2, 1);
        end_frame("back2back_b", 1'b0);

        // Reset asserted mid-frame: reset values, and the remainder of that frame is ignored
        start_frame();
        send_pixels(10, 6, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_thresh = 80;
        check("midrst.thresh", 32'(thresh), 32'd80);
        check("midrst.edge_cnt", 32'(edge_cnt), 32'd0);
        check("midrst.done", 32'(frame_done), 32'd0);
        check("midrst.err", 32'(frame_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_pixels(22, 10, 1);
        watch_no_done("midrst");

        // Normal operation resumes after the ignored frame
        start_frame(); send_pixels(NPIX, 20, 1); end_frame("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
